// File: rtl/palin_pkg.sv
// Shared types and constants for the palindrome scan controller.
package palin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } palin_state_e;

  // Cycles between a bit entering the detector and its Moore output reflecting it
  localparam int DET_LAT = 1;
  localparam int WIN     = 3;

  function automatic int max_hits(input int w);
    return w - WIN + 1;
  endfunction

endpackage

// File: rtl/palin_ser_shreg.sv
// W-bit parallel-load, shift-left register presenting its MSB for serialization.
module palin_ser_shreg
  import palin_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] data_r;

  // Load wins over shift; zeros backfill from the LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {W{1'b0}};
    end else if (load) begin
      data_r <= din;
    end else if (shift) begin
      data_r <= {data_r[W-2:0], 1'b0};
    end else begin
      data_r <= data_r;
    end
  end

  assign msb = data_r[W-1];

endmodule

// File: rtl/palin_scan_ctrl.sv
// Serializes a word into an external 3-bit palindrome detector and counts its hits.
module palin_scan_ctrl
  import palin_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_word,
  output logic          det_rst,
  output logic          det_bit,
  input  logic          det_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_hit,
  output logic          busy
);

  localparam int IW = $clog2(W);

  palin_state_e  state_r;
  palin_state_e  state_nx_s;
  logic [IW-1:0] bit_idx_r;
  logic [CW-1:0] count_r;
  logic          accept_s;
  logic          last_bit_s;
  logic          count_en_s;
  logic          shreg_msb_s;

  assign accept_s   = (state_r == ST_IDLE) && in_valid;
  assign last_bit_s = (bit_idx_r == IW'(W - 1));

  // Windows only become valid after the detector has seen enough bits
  assign count_en_s = det_out &&
                      (((state_r == ST_SHIFT) && (bit_idx_r >= IW'(DET_LAT))) ||
                       (state_r == ST_DRAIN));

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nx_s = ST_CLR;
        else          state_nx_s = ST_IDLE;
      end
      ST_CLR:   state_nx_s = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit_s) state_nx_s = ST_DRAIN;
        else            state_nx_s = ST_SHIFT;
      end
      ST_DRAIN: state_nx_s = ST_DONE;
      ST_DONE: begin
        if (res_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Bit index within the SHIFT phase
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_r <= {IW{1'b0}};
    end else if (state_r == ST_CLR) begin
      bit_idx_r <= {IW{1'b0}};
    end else if ((state_r == ST_SHIFT) && !last_bit_s) begin
      bit_idx_r <= bit_idx_r + IW'(1);
    end else begin
      bit_idx_r <= bit_idx_r;
    end
  end

  // Hit counter; cannot exceed W-2 so no saturation is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (accept_s) begin
      count_r <= {CW{1'b0}};
    end else if (count_en_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  palin_ser_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .shift (state_r == ST_SHIFT),
    .din   (in_word),
    .msb   (shreg_msb_s)
  );

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign res_valid = (state_r == ST_DONE);
  assign res_count = count_r;
  assign res_hit   = (count_r != {CW{1'b0}});
  assign det_bit   = (state_r == ST_SHIFT) && shreg_msb_s;
  assign det_rst   = rst || (state_r == ST_CLR);

endmodule

// File: tb/tb_palin_scan_ctrl.sv
// Randomized self-checking bench for palin_scan_ctrl with a 3-bit Moore palindrome detector attached.
module tb_palin_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_word;
  logic          det_rst;
  logic          det_bit;
  logic          det_out;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_hit;
  logic          busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  palin_scan_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .det_rst   (det_rst),
    .det_bit   (det_bit),
    .det_out   (det_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_hit   (res_hit),
    .busy      (busy)
  );

  // Attached detector: Moore, out=1 once three bits are held and the oldest equals the newest
  logic [2:0] det_hist;
  logic [1:0] det_seen;
  always @(posedge clk) begin
    if (det_rst) begin
      det_hist <= 3'b000;
      det_seen <= 2'd0;
    end else begin
      det_hist <= {det_hist[1:0], det_bit};
      det_seen <= (det_seen == 2'd3) ? 2'd3 : det_seen + 2'd1;
    end
  end
  assign det_out = (det_seen == 2'd3) && (det_hist[2] == det_hist[0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count of 3-bit windows whose outer bits match
  function automatic int model_hits(input logic [W-1:0] w);
    int n = 0;
    for (int k = 0; k <= W - 3; k++) if (w[k] == w[k+2]) n++;
    return n;
  endfunction

  // One job: accept, watch serialization, check latency/result, optionally stall in DONE
  task automatic run_job(input logic [W-1:0] w, input int hold, input logic [W-1:0] pend);
    int cyc;
    int exp_n;
    exp_n = model_hits(w);
    in_word  = w;
    in_valid = 1'b1;
    check("rdy_before", in_ready, 1);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 40) begin
      if (cyc == 1) check("clr_det_rst", det_rst, 1);
      if (cyc >= 2 && cyc <= W + 1) check("ser_bit", det_bit, w[W+1-cyc]);
      if (cyc == W + 2) check("drain_bit", det_bit, 0);
      tick();
      cyc++;
    end
    check("latency", cyc, W + 3);
    check("count", res_count, exp_n);
    check("hit", res_hit, exp_n != 0);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_word  = pend;
      for (int h = 0; h < hold; h++) begin
        tick();
        check("hold_valid", res_valid, 1);
        check("hold_count", res_count, exp_n);
        check("hold_rdy", in_ready, 0);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_rdy", in_ready, 1);
  endtask

  logic [W-1:0] bb_words [3];
  int           nres, wi, last_hs, cyc;
  logic         acc, hs;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    res_ready = 1'b0;
    tick();
    check("rst_det_rst", det_rst, 1);
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    check("rst_res_hit", res_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_det_bit", det_bit, 0);

    run_job(8'h00, 0, 8'h00);
    run_job(8'h55, 0, 8'h00);
    run_job(8'b0011_0011, 0, 8'h00);
    run_job(8'b1101_0010, 0, 8'h00);

    // Stall in DONE with a new word pending; it must be taken only after the handshake
    run_job(8'b1101_0010, 20, 8'h00);
    run_job(8'h00, 0, 8'h00);

    // Reset mid-SHIFT (bit index 4)
    in_word  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_det_rst", det_rst, 1);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rdy", in_ready, 1);
    check("mid_valid", res_valid, 0);
    check("mid_busy_clr", busy, 0);
    check("mid_det_bit", det_bit, 0);
    run_job(8'h00, 0, 8'h00);

    // Back-to-back streaming with res_ready held high
    bb_words[0] = 8'h00;
    bb_words[1] = 8'h55;
    bb_words[2] = 8'b1101_0010;
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = bb_words[0];
    wi = 0; nres = 0; last_hs = 0; cyc = 0;
    while (nres < 3 && cyc < 100) begin
      acc = in_valid & in_ready;
      hs  = res_valid & res_ready;
      if (hs) begin
        check("b2b_count", res_count, model_hits(bb_words[nres]));
        if (nres > 0) check("b2b_gap", cyc - last_hs, W + 4);
        last_hs = cyc;
        nres++;
      end
      tick();
      cyc++;
      if (acc) begin
        wi++;
        if (wi < 3) in_word = bb_words[wi];
        else        in_valid = 1'b0;
      end
    end
    check("b2b_results", nres, 3);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    tick();

    // Random words with random stalls
    for (int r = 0; r < 30; r++) begin
      run_job(W'($urandom), int'($urandom_range(0, 3)), W'($urandom));
      in_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
